// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// A fetch port (read-only) and a data port (read/write) share the memory, one transaction every 4 cycles.
module mem_arbiter #(
  parameter int unsigned A = 12,
  parameter int unsigned m = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         f_req,
  input  logic [A-1:0] f_addr,
  output logic         f_ack,
  output logic [m-1:0] f_rdata,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [A-1:0] d_addr,
  input  logic [m-1:0] d_wdata,
  output logic         d_ack,
  output logic [m-1:0] d_rdata,
  output logic [A-1:0] mem_address,
  output logic [m-1:0] mem_data_in,
  output logic         mem_we,
  output logic         mem_re,
  input  logic [m-1:0] mem_data_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

  state_t       r_state;
  logic         r_last_d;
  logic         r_gnt_d;
  logic         r_we;
  logic [A-1:0] r_addr;
  logic [m-1:0] r_wdata;
  logic [m-1:0] r_f_rdata;
  logic [m-1:0] r_d_rdata;
  logic         r_mem_we;
  logic         r_mem_re;
  logic         r_f_ack;
  logic         r_d_ack;
  logic         r_busy;
  logic         w_gnt_d;

  // Data wins when alone, or on a tie when fetch was granted last.
  assign w_gnt_d = d_req && (!f_req || !r_last_d);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b1;
      r_gnt_d   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
      r_mem_we  <= 1'b0;
      r_mem_re  <= 1'b0;
      r_f_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (f_req || d_req) begin
            r_gnt_d  <= w_gnt_d;
            r_last_d <= w_gnt_d;
            r_we     <= w_gnt_d && d_we;
            r_addr   <= w_gnt_d ? d_addr : f_addr;
            r_wdata  <= d_wdata;
            r_mem_we <= w_gnt_d && d_we;
            r_mem_re <= !(w_gnt_d && d_we);
            r_busy   <= 1'b1;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          r_mem_we <= 1'b0;
          r_mem_re <= 1'b0;
          r_state  <= RESP;
        end
        RESP: begin
          // Memory output is valid now: one cycle after the read strobe.
          if (!r_we) begin
            if (r_gnt_d) r_d_rdata <= mem_data_out;
            else         r_f_rdata <= mem_data_out;
          end
          r_f_ack <= !r_gnt_d;
          r_d_ack <= r_gnt_d;
          r_state <= DONE;
        end
        DONE: begin
          r_f_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign f_ack       = r_f_ack;
  assign d_ack       = r_d_ack;
  assign f_rdata     = r_f_rdata;
  assign d_rdata     = r_d_rdata;
  assign mem_address = r_addr;
  assign mem_data_in = r_wdata;
  assign mem_we      = r_mem_we;
  assign mem_re      = r_mem_re;
  assign busy        = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (shadow memory, fixed-latency schedule, round-robin rule).
module tb_mem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_ack;
  logic [DW-1:0] f_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_data_out = '0;
  logic          busy;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.A(AW), .m(DW)) dut (
    .CLK(CLK), .RST(RST),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_we(mem_we), .mem_re(mem_re), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Shared memory: registered read, address 0 reads 0 and drops writes.
  bit [DW-1:0] tbmem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (mem_we && mem_address != '0) tbmem[mem_address] <= mem_data_in;
    if (mem_re) mem_data_out <= (mem_address == '0) ? '0 : tbmem[mem_address];
  end

  // Reference model: a grant at edge g strobes the memory after g, acks after g+2,
  // and the next grant may happen no earlier than edge g+4.
  bit [DW-1:0]   shadow [0:(1<<AW)-1];
  int            edge_n = 0;
  int            t_g = 0;
  int            m_k;
  bit            active = 1'b0;
  bit            m_last_d = 1'b1;
  bit            m_gnt_d, m_we;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdval = '0;
  logic [DW-1:0] exp_f_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  bit            exp_re, exp_we, exp_f_ack, exp_d_ack, exp_busy;
  bit            chk_en = 1'b0;

  always @(posedge CLK) begin
    edge_n++;
    if (RST) begin
      active      = 1'b0;
      m_last_d    = 1'b1;
      exp_f_rdata = '0;
      exp_d_rdata = '0;
    end else begin
      if (active && edge_n - t_g >= 4) active = 1'b0;
      if (!active && (f_req || d_req)) begin
        if (f_req && d_req) m_gnt_d = !m_last_d;
        else                m_gnt_d = d_req;
        m_last_d = m_gnt_d;
        active   = 1'b1;
        t_g      = edge_n;
        m_we     = m_gnt_d && d_we;
        m_addr   = m_gnt_d ? d_addr : f_addr;
        m_wdata  = d_wdata;
        if (m_we) begin
          if (m_addr != '0) shadow[m_addr] = m_wdata;
        end else begin
          m_rdval = (m_addr == '0) ? '0 : shadow[m_addr];
        end
      end
    end
    m_k       = active ? edge_n - t_g : -1;
    exp_re    = active && m_k == 0 && !m_we;
    exp_we    = active && m_k == 0 && m_we;
    exp_f_ack = active && m_k == 2 && !m_gnt_d;
    exp_d_ack = active && m_k == 2 && m_gnt_d;
    exp_busy  = active && m_k <= 2;
    if (exp_f_ack && !m_we) exp_f_rdata = m_rdval;
    if (exp_d_ack && !m_we) exp_d_rdata = m_rdval;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check_eq("f_ack", 32'(f_ack), 32'(exp_f_ack));
      check_eq("d_ack", 32'(d_ack), 32'(exp_d_ack));
      check_eq("busy", 32'(busy), 32'(exp_busy));
      check_eq("mem_re", 32'(mem_re), 32'(exp_re));
      check_eq("mem_we", 32'(mem_we), 32'(exp_we));
      check_eq("f_rdata", 32'(f_rdata), 32'(exp_f_rdata));
      check_eq("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
      if (exp_re || exp_we) check_eq("mem_address", 32'(mem_address), 32'(m_addr));
      if (exp_we) check_eq("mem_data_in", 32'(mem_data_in), 32'(m_wdata));
    end
  end

  task automatic wait_ack(input bit is_d, output int cyc);
    cyc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (is_d ? d_ack : f_ack) begin
        cyc = edge_n;
        break;
      end
    end
    check_eq(is_d ? "d_ack_seen" : "f_ack_seen", 32'(is_d ? d_ack : f_ack), 32'd1);
  endtask

  task automatic data_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int s, e;
    @(negedge CLK);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    s = edge_n;
    wait_ack(1'b1, e);
    d_req = 1'b0;
    check_eq("d_latency", 32'(e - s), 32'd3);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic new_d_op();
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
    d_wdata = DW'($urandom);
  endtask

  initial begin
    int e;
    int n_acks;
    int ack_edge [4];
    bit ack_port [4];

    repeat (2) @(posedge CLK);
    chk_en = 1'b1;
    @(negedge CLK);
    check_eq("rst_mem_address", 32'(mem_address), 32'd0);
    check_eq("rst_mem_data_in", 32'(mem_data_in), 32'd0);
    RST = 1'b0;

    // Write then read back through the data port.
    data_txn(1'b1, AW'(12'h005), DW'(16'hBEEF));
    data_txn(1'b0, AW'(12'h005), '0);
    check_eq("rd_beef", 32'(d_rdata), 32'h0000BEEF);

    // Simultaneous requests after reset: fetch first, then alternate.
    pulse_reset();
    @(negedge CLK);
    f_req = 1'b1; f_addr = AW'(12'h005);
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(12'h005);
    n_acks = 0;
    for (int i = 0; i < 24 && n_acks < 4; i++) begin
      @(negedge CLK);
      if (f_ack && n_acks < 4) begin ack_port[n_acks] = 1'b0; ack_edge[n_acks] = edge_n; n_acks++; end
      if (d_ack && n_acks < 4) begin ack_port[n_acks] = 1'b1; ack_edge[n_acks] = edge_n; n_acks++; end
    end
    f_req = 1'b0; d_req = 1'b0;
    check_eq("tie_count", 32'(n_acks), 32'd4);
    for (int i = 0; i < n_acks; i++) begin
      check_eq("tie_order", 32'(ack_port[i]), 32'(i % 2));
      if (i > 0) check_eq("tie_gap", 32'(ack_edge[i] - ack_edge[i-1]), 32'd4);
    end

    // Address 0 accepts the write but always reads back zero.
    data_txn(1'b1, '0, DW'(16'h1234));
    data_txn(1'b0, '0, '0);
    check_eq("addr0_rd", 32'(d_rdata), 32'd0);

    // Reset while a fetch read sits in RESP: no ack, everything cleared.
    @(negedge CLK);
    f_req = 1'b1; f_addr = AW'(12'h005);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1; f_req = 1'b0;
    @(negedge CLK);
    check_eq("abort_f_ack", 32'(f_ack), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_f_rdata", 32'(f_rdata), 32'd0);
    check_eq("abort_mem_address", 32'(mem_address), 32'd0);
    RST = 1'b0;

    // Address change after grant must not redirect the read.
    data_txn(1'b1, AW'(12'h010), DW'(16'hA5A5));
    data_txn(1'b1, AW'(12'h0FF), DW'(16'h5A5A));
    @(negedge CLK);
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(12'h010);
    @(negedge CLK);
    d_addr = AW'(12'h0FF);
    check_eq("latched_addr", 32'(mem_address), 32'h010);
    wait_ack(1'b1, e);
    d_req = 1'b0;
    check_eq("latched_rdata", 32'(d_rdata), 32'h0000A5A5);

    // Random traffic with occasional resets and post-grant input scrambling.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 99) == 0) RST = 1'b1;
      if (f_req && f_ack) begin
        if ($urandom_range(0, 1) == 0) f_req = 1'b0;
        else f_addr = AW'($urandom_range(0, 7));
      end else if (!f_req && $urandom_range(0, 2) == 0) begin
        f_req  = 1'b1;
        f_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      end
      if (d_req && d_ack) begin
        if ($urandom_range(0, 1) == 0) d_req = 1'b0;
        else new_d_op();
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        new_d_op();
      end else if (d_req && active && m_gnt_d && $urandom_range(0, 3) == 0) begin
        new_d_op();
      end
    end
    RST = 1'b0; f_req = 1'b0; d_req = 1'b0;
    repeat (6) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
